// File: rtl/eth_motor_cmd_parser_if.sv
// Byte stream in and decoded command out for the motor command parser.
// The parser uses the slave modport; the stream source and command sink use master.
interface eth_motor_cmd_parser_if #(
    parameter int MAX_ARG_BYTES = 8
);
    logic                       ETH_MOTOR_TVALID;
    logic                       ETH_MOTOR_TREADY;
    logic                       ETH_MOTOR_TLAST;
    logic [7:0]                 ETH_MOTOR_TDATA;
    logic                       CMD_VALID;
    logic                       CMD_READY;
    logic [7:0]                 CMD_CODE;
    logic [3:0]                 CMD_LEN;
    logic [MAX_ARG_BYTES*8-1:0] CMD_ARG;

    modport slave (
        input  ETH_MOTOR_TVALID,
        input  ETH_MOTOR_TLAST,
        input  ETH_MOTOR_TDATA,
        output ETH_MOTOR_TREADY,
        output CMD_VALID,
        output CMD_CODE,
        output CMD_LEN,
        output CMD_ARG,
        input  CMD_READY
    );

    modport master (
        output ETH_MOTOR_TVALID,
        output ETH_MOTOR_TLAST,
        output ETH_MOTOR_TDATA,
        input  ETH_MOTOR_TREADY,
        input  CMD_VALID,
        input  CMD_CODE,
        input  CMD_LEN,
        input  CMD_ARG,
        output CMD_READY
    );
endinterface

// File: rtl/eth_motor_cmd_parser.sv
// Motor command frame parser: SYNC, CMD, LEN, args, XOR checksum.
// Optional counters GOOD_CNT/ERR_CNT are built when MOTOR_CMD_STATS_EN is defined.
module eth_motor_cmd_parser #(
    parameter int         MAX_ARG_BYTES = 8,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic                  CLK_125M,
    input  logic                  SYS_RST_N,
    eth_motor_cmd_parser_if.slave bus,
    output logic                  ERR_PULSE,
    output logic [2:0]            ERR_TYPE,
    output logic [15:0]           GOOD_CNT,
    output logic [15:0]           ERR_CNT
);
    localparam int         AW      = MAX_ARG_BYTES * 8;
    localparam logic [7:0] MAX_LEN = 8'(MAX_ARG_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_ARG, S_CSUM, S_OUT, S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic            rdy_q;
    logic [7:0]      code_q, acc_q;
    logic [3:0]      len_q, idx_q;
    logic [AW-1:0]   arg_q;
    logic            err_pulse_q;
    logic [2:0]      err_type_q;
    logic            err_v;
    logic [2:0]      err_c;
    logic            beat, last;
    logic [7:0]      data;

    assign data = bus.ETH_MOTOR_TDATA;
    assign last = bus.ETH_MOTOR_TLAST;
    assign beat = bus.ETH_MOTOR_TVALID && rdy_q;

    always_comb begin
        state_d = state_q;
        err_v   = 1'b0;
        err_c   = 3'd0;
        case (state_q)
            S_IDLE: if (beat) begin
                if (data == SYNC_BYTE) begin
                    state_d = S_CMD;
                end else begin
                    err_v   = 1'b1;
                    err_c   = 3'd1;
                    state_d = last ? S_IDLE : S_DRAIN;
                end
            end
            S_CMD: if (beat) begin
                if (last) begin
                    err_v   = 1'b1;
                    err_c   = 3'd3;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_LEN: if (beat) begin
                // Oversize length wins over a premature TLAST
                if (data > MAX_LEN) begin
                    err_v   = 1'b1;
                    err_c   = 3'd2;
                    state_d = last ? S_IDLE : S_DRAIN;
                end else if (last) begin
                    err_v   = 1'b1;
                    err_c   = 3'd3;
                    state_d = S_IDLE;
                end else if (data == 8'd0) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_ARG;
                end
            end
            S_ARG: if (beat) begin
                if (last) begin
                    err_v   = 1'b1;
                    err_c   = 3'd3;
                    state_d = S_IDLE;
                end else if (idx_q == len_q - 4'd1) begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: if (beat) begin
                if (data != acc_q) begin
                    err_v   = 1'b1;
                    err_c   = 3'd4;
                    state_d = last ? S_IDLE : S_DRAIN;
                end else if (!last) begin
                    err_v   = 1'b1;
                    err_c   = 3'd5;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_OUT: if (bus.CMD_READY) state_d = S_IDLE;
            S_DRAIN: if (beat && last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_125M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            code_q      <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            arg_q       <= '0;
            err_pulse_q <= 1'b0;
            err_type_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= (state_d != S_OUT);
            err_pulse_q <= err_v;
            if (err_v) err_type_q <= err_c;
            if (beat) begin
                case (state_q)
                    S_CMD: begin
                        code_q <= data;
                        acc_q  <= data;
                    end
                    S_LEN: begin
                        acc_q <= acc_q ^ data;
                        len_q <= data[3:0];
                        arg_q <= '0;
                        idx_q <= '0;
                    end
                    S_ARG: begin
                        acc_q <= acc_q ^ data;
                        idx_q <= idx_q + 4'd1;
                        for (int i = 0; i < MAX_ARG_BYTES; i++)
                            if (idx_q == 4'(i)) arg_q[i*8 +: 8] <= data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ETH_MOTOR_TREADY = rdy_q;
    assign bus.CMD_VALID        = (state_q == S_OUT);
    assign bus.CMD_CODE         = code_q;
    assign bus.CMD_LEN          = len_q;
    assign bus.CMD_ARG          = arg_q;
    assign ERR_PULSE            = err_pulse_q;
    assign ERR_TYPE             = err_type_q;

`ifdef MOTOR_CMD_STATS_EN
    logic [15:0] good_cnt_q, err_cnt_q;

    always_ff @(posedge CLK_125M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (bus.CMD_VALID && bus.CMD_READY && good_cnt_q != 16'hFFFF)
                good_cnt_q <= good_cnt_q + 16'd1;
            if (err_pulse_q && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign GOOD_CNT = good_cnt_q;
    assign ERR_CNT  = err_cnt_q;
`else
    assign GOOD_CNT = 16'd0;
    assign ERR_CNT  = 16'd0;
`endif
endmodule

// File: tb/tb_eth_motor_cmd_parser.sv
// Directed bench for eth_motor_cmd_parser: frame table plus stall,
// reset and (with MOTOR_CMD_STATS_EN) counter sequences.
module tb_eth_motor_cmd_parser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_pulse;
    logic [2:0]  err_type;
    logic [15:0] good_cnt, err_cnt;

    always #4 clk = ~clk;

    eth_motor_cmd_parser_if #(.MAX_ARG_BYTES(8)) bus ();

    eth_motor_cmd_parser #(.MAX_ARG_BYTES(8), .SYNC_BYTE(8'hA5)) dut (
        .CLK_125M  (clk),
        .SYS_RST_N (rst_n),
        .bus       (bus.slave),
        .ERR_PULSE (err_pulse),
        .ERR_TYPE  (err_type),
        .GOOD_CNT  (good_cnt),
        .ERR_CNT   (err_cnt)
    );

    typedef struct {
        logic [95:0] b;
        int          n;
        int          gap;
        bit          exp_v;
        logic [7:0]  code;
        logic [3:0]  len;
        logic [63:0] arg;
        int          exp_e;
        logic [2:0]  et;
    } vec_t;

    vec_t vt [11];
    int checks = 0;
    int errors = 0;
    int n_err = 0;
    int n_hs = 0;

    always @(negedge clk) begin
        if (err_pulse) n_err++;
        if (bus.CMD_VALID && bus.CMD_READY) n_hs++;
    end

    function automatic vec_t mk(input logic [95:0] b, input int n, input int gap,
                                input bit v, input logic [7:0] c, input logic [3:0] l,
                                input logic [63:0] a, input int e, input logic [2:0] et);
        vec_t r;
        r.b = b; r.n = n; r.gap = gap; r.exp_v = v; r.code = c;
        r.len = l; r.arg = a; r.exp_e = e; r.et = et;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit l);
        bit ok;
        ok = 1'b0;
        bus.ETH_MOTOR_TVALID = 1'b1;
        bus.ETH_MOTOR_TDATA  = d;
        bus.ETH_MOTOR_TLAST  = l;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (bus.ETH_MOTOR_TREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got tready=0 want 1");
        end else begin
            @(posedge clk);
            #1;
        end
        bus.ETH_MOTOR_TVALID = 1'b0;
        bus.ETH_MOTOR_TLAST  = 1'b0;
    endtask

    task automatic send_frame(input int i);
        for (int k = 0; k < vt[i].n; k++) begin
            send(vt[i].b[(11-k)*8 +: 8], k == vt[i].n - 1);
            if (k != vt[i].n - 1)
                repeat (vt[i].gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic run_vec(input int i);
        int e0, h0;
        e0 = n_err;
        h0 = n_hs;
        send_frame(i);
        if (vt[i].exp_v) begin
            chk($sformatf("v%0d_valid", i), 64'(bus.CMD_VALID), 64'd1);
            chk($sformatf("v%0d_code", i), 64'(bus.CMD_CODE), 64'(vt[i].code));
            chk($sformatf("v%0d_len", i), 64'(bus.CMD_LEN), 64'(vt[i].len));
            chk($sformatf("v%0d_arg", i), bus.CMD_ARG, vt[i].arg);
        end
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_cmds", i), 64'(n_hs - h0), 64'(vt[i].exp_v));
        chk($sformatf("v%0d_errs", i), 64'(n_err - e0), 64'(vt[i].exp_e));
        if (vt[i].exp_e != 0)
            chk($sformatf("v%0d_etype", i), 64'(err_type), 64'(vt[i].et));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = mk({8'hA5, 8'h10, 8'h02, 8'h34, 8'h12, 8'h34, {6{8'h00}}},
                    6, 0, 1, 8'h10, 4'd2, 64'h1234, 0, 3'd0);
        vt[1]  = mk({8'hA5, 8'h10, 8'h02, 8'h34, 8'h12, 8'h00, {6{8'h00}}},
                    6, 0, 0, 8'h00, 4'd0, 64'h0, 1, 3'd4);
        vt[2]  = mk({8'hA5, 8'h10, 8'h09, 8'h11, 8'h22, 8'h33, {6{8'h00}}},
                    6, 0, 0, 8'h00, 4'd0, 64'h0, 1, 3'd2);
        vt[3]  = mk({8'h5A, 8'h10, 8'h20, {9{8'h00}}},
                    3, 0, 0, 8'h00, 4'd0, 64'h0, 1, 3'd1);
        vt[4]  = mk({8'hA5, 8'h20, 8'h03, 8'hAA, {8{8'h00}}},
                    4, 0, 0, 8'h00, 4'd0, 64'h0, 1, 3'd3);
        vt[5]  = mk({8'hA5, 8'h20, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hFE, {5{8'h00}}},
                    7, 0, 1, 8'h20, 4'd3, 64'hCCBBAA, 0, 3'd0);
        vt[6]  = mk({8'hA5, 8'h10, 8'h02, 8'h34, 8'h12, 8'h34, 8'h77, {5{8'h00}}},
                    7, 0, 0, 8'h00, 4'd0, 64'h0, 1, 3'd5);
        vt[7]  = mk({8'hA5, 8'h33, 8'h00, 8'h33, {8{8'h00}}},
                    4, 1, 1, 8'h33, 4'd0, 64'h0, 0, 3'd0);
        vt[8]  = mk({8'hA5, 8'h40, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                     8'h05, 8'h06, 8'h07, 8'h08, 8'h40},
                    12, 1, 1, 8'h40, 4'd8, 64'h0807060504030201, 0, 3'd0);
        vt[9]  = mk({8'h5A, {11{8'h00}}},
                    1, 0, 0, 8'h00, 4'd0, 64'h0, 1, 3'd1);
        vt[10] = vt[0];

        bus.ETH_MOTOR_TVALID = 1'b0;
        bus.ETH_MOTOR_TLAST  = 1'b0;
        bus.ETH_MOTOR_TDATA  = 8'h00;
        bus.CMD_READY        = 1'b1;

        #20;
        chk("rst_tready", 64'(bus.ETH_MOTOR_TREADY), 64'd0);
        chk("rst_valid", 64'(bus.CMD_VALID), 64'd0);
        chk("rst_code_len", 64'({bus.CMD_CODE, bus.CMD_LEN}), 64'd0);
        chk("rst_arg", bus.CMD_ARG, 64'd0);
        chk("rst_err", 64'({err_pulse, err_type}), 64'd0);
        chk("rst_cnts", 64'({good_cnt, err_cnt}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 64'(bus.ETH_MOTOR_TREADY), 64'd1);

        for (int i = 0; i < 11; i++) run_vec(i);

        // Sink stalls 20 cycles while the next frame is already offered
        begin
            int h0;
            h0 = n_hs;
            bus.CMD_READY = 1'b0;
            send_frame(0);
            chk("stall_valid", 64'(bus.CMD_VALID), 64'd1);
            fork
                begin
                    for (int c = 0; c < 20; c++) begin
                        @(negedge clk);
                        chk("stall_hold",
                            64'({bus.ETH_MOTOR_TREADY, bus.CMD_VALID,
                                 bus.CMD_CODE, bus.CMD_LEN, bus.CMD_ARG[31:0]}),
                            64'({1'b0, 1'b1, 8'h10, 4'd2, 32'h1234}));
                    end
                    bus.CMD_READY = 1'b1;
                end
                send_frame(5);
            join
            chk("stall2_valid", 64'(bus.CMD_VALID), 64'd1);
            chk("stall2_code", 64'(bus.CMD_CODE), 64'h20);
            chk("stall2_arg", bus.CMD_ARG, 64'hCCBBAA);
            repeat (3) @(negedge clk);
            chk("stall_cmds", 64'(n_hs - h0), 64'd2);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of the argument bytes
        send(8'hA5, 1'b0);
        send(8'h10, 1'b0);
        send(8'h05, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mrst_tready", 64'(bus.ETH_MOTOR_TREADY), 64'd0);
        chk("mrst_cmd", 64'({bus.CMD_VALID, bus.CMD_CODE, bus.CMD_LEN}), 64'd0);
        chk("mrst_arg", bus.CMD_ARG, 64'd0);
        chk("mrst_err", 64'({err_pulse, err_type}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(0);

`ifdef MOTOR_CMD_STATS_EN
        do_reset();
        run_vec(0);
        run_vec(1);
        run_vec(5);
        run_vec(3);
        run_vec(7);
        chk("good_cnt", 64'(good_cnt), 64'd3);
        chk("err_cnt", 64'(err_cnt), 64'd2);
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_cnt_q;
        run_vec(9);
        run_vec(9);
        run_vec(9);
        chk("err_cnt_sat", 64'(err_cnt), 64'hFFFF);
`else
        chk("good_cnt_off", 64'(good_cnt), 64'd0);
        chk("err_cnt_off", 64'(err_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
